store_buffer: RTL and testbench
===============================

// Module: store_buffer
// PURPOSE
//  Four-entry coalescing store buffer between the pipeline's memory stage and the D-cache.
//  - Stores that hit the cache are parked here as {address,data} pairs.
//  - Loads are forwarded from the buffer on an address match.
//  - Entries drain to the cache in FIFO order whenever the cache signals it can accept a write.
// PARAMETERS
//  DEPTH   4   number of entries (power of two)
//  ADDR_W  32  address width
//  DATA_W  32  data width; data_to_cache is ADDR_W+DATA_W wide
// PORTS
//  clk                    in   1   clock, all state updates on rising edge
//  reset                  in   1   synchronous, active-high
//  flush                  in   1   sync clear of all entries (pipeline squash)
//  is_load                in   1   memory-stage load this cycle
//  is_store               in   1   memory-stage store this cycle
//  address                in   32  load/store byte address (full-word compare)
//  writedata              in   32  store data
//  cache_ready_to_catch   in   1   cache can accept one drained entry this cycle
//  cache_hit              in   1   store address hits in the cache
//  data_read              out  32  forwarded load data
//  hit_storeBuffer        out  1   load matched a valid entry
//  data_to_cache          out  64  {addr[63:32], data[31:0]} of oldest entry
//  sending_data_to_cache  out  1   data_to_cache is valid and popped at this edge
//  storeBuffer_full       out  1   all DEPTH entries valid
//  exists_address         in   1   reserved hint; ignored; X-tolerant (DUT does its own match)
// BEHAVIOUR
//  - State: DEPTH x {addr, data, valid}, head/tail pointers (wrap mod DEPTH), count 0..DEPTH.
//  - Reset or flush: all valid=0, head=tail=count=0; reset has priority over everything.
//  - Reset values of outputs: data_read=0, hit_storeBuffer=0, data_to_cache=0,
//    sending_data_to_cache=0, storeBuffer_full=0.
//  - All outputs are combinational from state and inputs; updates take effect next edge.
//  Load forwarding (0 latency)
//   - When is_load, compare address against all valid entries.
//   - On match: hit_storeBuffer=1, data_read=matching entry data.
//   - Otherwise, or when !is_load: hit_storeBuffer=0, data_read=0.
//   - At most one entry matches (stores coalesce).
//  Store accept: is_store && cache_hit && !is_load; a store with cache_hit=0 is ignored (miss path).
//   - Match on a valid entry that is not being drained this cycle: overwrite its data, count unchanged.
//   - Otherwise, if count<DEPTH before this edge: write {address,writedata} at tail, tail++, count++.
//   - Otherwise (full) the store is dropped; the pipeline must stall on storeBuffer_full.
//  Drain
//   - sending_data_to_cache = cache_ready_to_catch && count>0.
//   - data_to_cache={head.addr,head.data} when count>0, else 0.
//   - On sending: head invalidated, head++, count-- at the edge.
//  Simultaneous events
//   - Drain and push in the same cycle: count net unchanged.
//   - Push is still refused if full at cycle start.
//   - A store matching the head being drained allocates a new entry (old data drains unchanged).
//  Flags: storeBuffer_full = (count==DEPTH).
// TESTING
//  1. reset=1 one edge -> all outputs 0, storeBuffer_full=0.
//  2. Four stores, cache_hit=1:
//     (00010001,00010AA0), (00010331,00010BB0), (000100F1,00010AA0), (0AA10001,00010AA0)
//     -> storeBuffer_full=1 after 4th edge.
//  3. Store 00010FFF/00010BB0 with cache_hit=0 -> no change.
//     Then a store with cache_hit=1 while full -> dropped, count stays 4.
//  4. is_load at 00010331 -> hit_storeBuffer=1, data_read=00010BB0.
//     At 00010001 -> 00010AA0.
//     At 00010FFF -> hit=0, data_read=0.
//  5. cache_ready_to_catch=1 for 4 cycles:
//     - data_to_cache = 0001000100010AA0, 0001033100010BB0, 000100F100010AA0, 0AA1000100010AA0 in order.
//     - sending=1 each cycle; full=0 after first pop; then sending=0, data_to_cache=0.
//  6. Store to an existing non-head address 00010331 with new data 12345678
//     -> count unchanged, later load returns 12345678.
//     Then flush=1 -> all entries gone, load miss.

Source files
------------

// File: rtl/store_buffer_if.sv
// store_buffer_if
//   Bundles the memory-stage / D-cache side of the store buffer.
//   master : pipeline + cache side (drives requests, reads results)
//   slave  : the store buffer itself
//   Signals:
//     flush, is_load, is_store, address, writedata : memory-stage requests
//     cache_ready_to_catch, cache_hit              : D-cache status
//     exists_address                               : reserved hint, ignored by the buffer
//     data_read, hit_storeBuffer                   : load forwarding result
//     data_to_cache, sending_data_to_cache         : drain port
//     storeBuffer_full                             : stall request to the pipeline
//   Handshake: the drain port is valid/ready. sending_data_to_cache is the
//   transfer strobe (entry present AND cache_ready_to_catch); data_to_cache
//   must be captured by the cache on any rising edge where it is 1, and the
//   entry is retired on that same edge.
interface store_buffer_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                       flush;
    logic                       is_load;
    logic                       is_store;
    logic [ADDR_W-1:0]          address;
    logic [DATA_W-1:0]          writedata;
    logic                       cache_ready_to_catch;
    logic                       cache_hit;
    logic                       exists_address;
    logic [DATA_W-1:0]          data_read;
    logic                       hit_storeBuffer;
    logic [ADDR_W+DATA_W-1:0]   data_to_cache;
    logic                       sending_data_to_cache;
    logic                       storeBuffer_full;

    modport master (
        output flush, is_load, is_store, address, writedata,
               cache_ready_to_catch, cache_hit, exists_address,
        input  data_read, hit_storeBuffer, data_to_cache,
               sending_data_to_cache, storeBuffer_full
    );

    modport slave (
        input  flush, is_load, is_store, address, writedata,
               cache_ready_to_catch, cache_hit, exists_address,
        output data_read, hit_storeBuffer, data_to_cache,
               sending_data_to_cache, storeBuffer_full
    );
endinterface

// File: rtl/store_buffer.sv
// store_buffer
//   Coalescing FIFO store buffer between the memory stage and the D-cache.
//   Cache-hitting stores are parked as {address,data}; loads are forwarded
//   from a matching entry with zero latency; entries drain oldest-first
//   whenever the cache can take one.
//   Ports:
//     clk   : clock, all state changes on the rising edge
//     reset : synchronous, active-high, dominates everything
//     bus   : store_buffer_if.slave (request, forwarding and drain signals)
module store_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input logic           clk,
    input logic           reset,
    store_buffer_if.slave bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DEPTH-1:0]  valid_q;
    logic [PTR_W-1:0]  head_q;
    logic [PTR_W-1:0]  tail_q;
    logic [CNT_W-1:0]  count_q;

    logic [DEPTH-1:0]  match_vec;
    logic              match_any;
    logic [PTR_W-1:0]  match_idx;
    logic              not_empty;
    logic              sending;
    logic              store_acc;
    logic              coalesce;
    logic              push;

    // The hint is deliberately ignored; the buffer does its own address match.
    logic unused_exists;
    assign unused_exists = bus.exists_address;

    always_comb begin
        match_vec = '0;
        match_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            match_vec[i] = valid_q[i] && (addr_q[i] == bus.address);
            if (match_vec[i]) match_idx = PTR_W'(i);
        end
    end

    assign match_any = |match_vec;
    assign not_empty = (count_q != '0);
    assign sending   = bus.cache_ready_to_catch && not_empty;
    assign store_acc = bus.is_store && bus.cache_hit && !bus.is_load;
    // A hit on the entry leaving this cycle must not be merged into it: the old
    // data still goes to the cache and the new store gets its own slot.
    assign coalesce  = store_acc && match_any && !(sending && (match_idx == head_q));
    // Capacity is judged on the count at cycle start, so a full buffer refuses
    // a new entry even while it drains.
    assign push      = store_acc && !coalesce && (count_q != FULL_CNT);

    assign bus.hit_storeBuffer       = bus.is_load && match_any;
    assign bus.data_read             = (bus.is_load && match_any) ? data_q[match_idx] : '0;
    assign bus.sending_data_to_cache = sending;
    assign bus.data_to_cache         = not_empty ? {addr_q[head_q], data_q[head_q]} : '0;
    assign bus.storeBuffer_full      = (count_q == FULL_CNT);

    always_ff @(posedge clk) begin
        if (reset || bus.flush) begin
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (sending) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + 1'b1;
            end
            if (coalesce) begin
                data_q[match_idx] <= bus.writedata;
            end
            // push implies not full, so tail never equals a draining head here.
            if (push) begin
                addr_q[tail_q]  <= bus.address;
                data_q[tail_q]  <= bus.writedata;
                valid_q[tail_q] <= 1'b1;
                tail_q          <= tail_q + 1'b1;
            end
            case ({push, sending})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end
endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;
    localparam int DEPTH = 4;

    logic clk;
    logic reset;

    store_buffer_if sb_if ();

    store_buffer #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (sb_if)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    // Buffer contents in FIFO order as {addr,data}; drained entries are popped
    // and compared against data_to_cache.
    logic [63:0] exp_q[$];
    int n_vec      = 0;
    int n_miscmp   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_idle();
        sb_if.flush                = 1'b0;
        sb_if.is_load              = 1'b0;
        sb_if.is_store             = 1'b0;
        sb_if.address              = '0;
        sb_if.writedata            = '0;
        sb_if.cache_ready_to_catch = 1'b0;
        sb_if.cache_hit            = 1'b0;
        sb_if.exists_address       = 1'bx;
    endtask

    function automatic int find_idx(input logic [31:0] a);
        find_idx = -1;
        foreach (exp_q[i]) if (exp_q[i][63:32] == a) find_idx = i;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(negedge clk);
        set_idle();
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        exp_q.delete();
    endtask

    task automatic check_idle_outputs(input string tag);
        @(negedge clk);
        set_idle();
        #1;
        check({tag, "_data_read"}, 64'(sb_if.data_read), 64'h0);
        check({tag, "_hit"}, 64'(sb_if.hit_storeBuffer), 64'h0);
        check({tag, "_sending"}, 64'(sb_if.sending_data_to_cache), 64'h0);
        check({tag, "_to_cache"}, sb_if.data_to_cache,
              (exp_q.size() > 0) ? exp_q[0] : 64'h0);
        check({tag, "_full"}, 64'(sb_if.storeBuffer_full), 64'(exp_q.size() == DEPTH));
    endtask

    // Store with optional simultaneous drain request.
    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic hit,
                         input logic drain);
        logic full_before;
        int   idx;
        @(negedge clk);
        set_idle();
        sb_if.is_store             = 1'b1;
        sb_if.address              = a;
        sb_if.writedata            = d;
        sb_if.cache_hit            = hit;
        sb_if.cache_ready_to_catch = drain;
        #1;
        full_before = (exp_q.size() == DEPTH);
        check("st_full", 64'(sb_if.storeBuffer_full), 64'(full_before));
        if (drain) begin
            check("st_sending", 64'(sb_if.sending_data_to_cache), 64'(exp_q.size() > 0));
            check("st_to_cache", sb_if.data_to_cache, (exp_q.size() > 0) ? exp_q[0] : 64'h0);
        end
        @(posedge clk);
        #1;
        if (drain && exp_q.size() > 0) void'(exp_q.pop_front());
        if (hit) begin
            idx = find_idx(a);
            if (idx >= 0) exp_q[idx][31:0] = d;
            else if (!full_before) exp_q.push_back({a, d});
        end
    endtask

    task automatic load(input logic [31:0] a);
        int idx;
        @(negedge clk);
        set_idle();
        sb_if.is_load  = 1'b1;
        sb_if.is_store = 1'($urandom_range(0, 1)); // a store alongside a load is never accepted
        sb_if.cache_hit = 1'b1;
        sb_if.address  = a;
        sb_if.writedata = $urandom;
        #1;
        idx = find_idx(a);
        check("ld_hit", 64'(sb_if.hit_storeBuffer), 64'(idx >= 0));
        check("ld_data", 64'(sb_if.data_read), (idx >= 0) ? 64'(exp_q[idx][31:0]) : 64'h0);
        @(posedge clk);
        #1;
    endtask

    task automatic drain_cycle();
        @(negedge clk);
        set_idle();
        sb_if.cache_ready_to_catch = 1'b1;
        #1;
        check("dr_sending", 64'(sb_if.sending_data_to_cache), 64'(exp_q.size() > 0));
        check("dr_to_cache", sb_if.data_to_cache, (exp_q.size() > 0) ? exp_q[0] : 64'h0);
        check("dr_full", 64'(sb_if.storeBuffer_full), 64'(exp_q.size() == DEPTH));
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
    endtask

    task automatic do_flush();
        @(negedge clk);
        set_idle();
        sb_if.flush = 1'b1;
        @(posedge clk);
        #1;
        exp_q.delete();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] pool [6];
        set_idle();
        reset = 1'b0;
        do_reset();
        check_idle_outputs("reset");

        store(32'h0001_0001, 32'h0001_0AA0, 1'b1, 1'b0);
        store(32'h0001_0331, 32'h0001_0BB0, 1'b1, 1'b0);
        store(32'h0001_00F1, 32'h0001_0AA0, 1'b1, 1'b0);
        store(32'h0AA1_0001, 32'h0001_0AA0, 1'b1, 1'b0);
        check_idle_outputs("after4");

        store(32'h0001_0FFF, 32'h0001_0BB0, 1'b0, 1'b0);  // cache miss: ignored
        store(32'h0001_0FFF, 32'h0BAD_F00D, 1'b1, 1'b0);  // full: dropped
        check_idle_outputs("full_drop");

        load(32'h0001_0331);
        load(32'h0001_0001);
        load(32'h0001_0FFF);

        for (int i = 0; i < DEPTH + 1; i++) drain_cycle();
        check_idle_outputs("drained");

        store(32'h0001_0001, 32'h1111_0000, 1'b1, 1'b0);
        store(32'h0001_0331, 32'h0001_0BB0, 1'b1, 1'b0);
        store(32'h0001_0331, 32'h1234_5678, 1'b1, 1'b0);  // coalesce, non-head
        load(32'h0001_0331);
        // store to the head address while it drains: new entry, old data drains
        store(32'h0001_0001, 32'h2222_0000, 1'b1, 1'b1);
        load(32'h0001_0001);
        do_flush();
        load(32'h0001_0331);
        check_idle_outputs("flushed");

        for (int k = 0; k < 6; k++) pool[k] = 32'h0002_0000 + 32'(k * 4);
        for (int n = 0; n < 120; n++) begin
            case ($urandom_range(0, 3))
                0: store(pool[$urandom_range(0, 5)], $urandom, 1'($urandom_range(0, 3) != 0), 1'b0);
                1: load(pool[$urandom_range(0, 5)]);
                2: drain_cycle();
                default: store(pool[$urandom_range(0, 5)], $urandom, 1'b1, 1'b1);
            endcase
        end
        for (int i = 0; i < DEPTH + 1; i++) drain_cycle();

        do_reset();
        check_idle_outputs("reset2");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end
endmodule
